// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel clock/strobe divider.
// Optional macro CLK_DIV_DUTY_EN adds a per-channel duty field to the config record.
package clk_div_pkg;

  // Default divide-ratio width.
  localparam int DEF_DIV_W = 8;

  // Channel index wide enough for the largest supported channel count (8).
  localparam int CH_IDX_W = 3;
  typedef logic [CH_IDX_W-1:0] ch_idx_t;

  // Config fields are held at the widest supported ratio; the top narrows
  // them back to its own DIV_W (which must not exceed CFG_DIV_W).
  localparam int CFG_DIV_W = 16;

  typedef struct packed {
    ch_idx_t               ch;
    logic [CFG_DIV_W-1:0]  div;
`ifdef CLK_DIV_DUTY_EN
    logic [CFG_DIV_W-1:0]  duty;
`endif
  } cfg_t;

  // High-phase length of a square wave: ceil(div/2).
  function automatic logic [31:0] half_ceil(input logic [31:0] d);
    return (d + 32'd1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_multi_chan.sv
// One divider channel: period counter, ratio (and optional duty) register,
// registered square output and one-cycle strobe.
// Optional macro CLK_DIV_DUTY_EN replaces ceil(div/2) with a programmed duty.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [DIV_W-1:0] load_div,
`ifdef CLK_DIV_DUTY_EN
  input  logic [DIV_W-1:0] load_duty,
`endif
  output logic             wrap,
  output logic             ch_out,
  output logic             ch_stb
);

  localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic             RST_OUT = (DEFAULT_DIV >= 1);
`ifdef CLK_DIV_DUTY_EN
  localparam logic [DIV_W-1:0] RST_DUTY = DIV_W'(half_ceil(32'(DEFAULT_DIV)));
`endif

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             out_q, out_d;
  logic             stb_q, stb_d;
  logic [DIV_W-1:0] high_d;
  logic             enabled;
  logic             at_wrap;
`ifdef CLK_DIV_DUTY_EN
  logic [DIV_W-1:0] duty_q, duty_d;
`endif

  // Next-state: advance on tick, reload at a period boundary, derive output.
  // A disabled channel counts as permanently sitting on a boundary so a
  // pending write to it lands on the very next edge.
  always_comb begin
    enabled = (div_q != '0);
    at_wrap = tick && enabled && (cnt_q == div_q - DIV_W'(1));
    wrap    = at_wrap || !enabled;
    cnt_d   = cnt_q;
    div_d   = div_q;
    stb_d   = 1'b0;
`ifdef CLK_DIV_DUTY_EN
    duty_d  = duty_q;
`endif
    if (tick && enabled) begin
      if (at_wrap) begin
        cnt_d = '0;
        stb_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
    if (load && wrap) begin
      div_d = load_div;
      cnt_d = '0;
`ifdef CLK_DIV_DUTY_EN
      duty_d = load_duty;
`endif
    end
`ifdef CLK_DIV_DUTY_EN
    high_d = duty_d;
`else
    high_d = DIV_W'(half_ceil(32'(div_d)));
`endif
    out_d = (div_d != '0) && (cnt_d < high_d);
  end

  // Channel state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= RST_DIV;
      out_q <= RST_OUT;
      stb_q <= 1'b0;
`ifdef CLK_DIV_DUTY_EN
      duty_q <= RST_DUTY;
`endif
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      out_q <= out_d;
      stb_q <= stb_d;
`ifdef CLK_DIV_DUTY_EN
      duty_q <= duty_d;
`endif
    end
  end

  assign ch_out = out_q;
  assign ch_stb = stb_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock/strobe divider: shared prescaler, single pending
// config slot, NUM_CH independently programmable divider channels.
// Optional macro CLK_DIV_DUTY_EN adds the cfg_duty port.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int PRESCALE_W  = 25,
  parameter int DIV_W       = clk_div_pkg::DEF_DIV_W,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      en,
  input  logic                                      cfg_valid,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
  input  logic [DIV_W-1:0]                          cfg_div,
`ifdef CLK_DIV_DUTY_EN
  input  logic [DIV_W-1:0]                          cfg_duty,
`endif
  output logic                                      cfg_ready,
  output logic                                      tick,
  output logic [NUM_CH-1:0]                         ch_out,
  output logic [NUM_CH-1:0]                         ch_stb
);

  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic                  tick_q, tick_d;
  cfg_t                  pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic                  pend_in_range;
  logic                  applied;
  logic [NUM_CH-1:0]     load;
  logic [NUM_CH-1:0]     wrap;

  // Prescaler: free-running counter, tick registered on the wrap edge.
  always_comb begin
    pre_cnt_d = pre_cnt_q;
    tick_d    = 1'b0;
    if (en) begin
      pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
      tick_d    = &pre_cnt_q;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      tick_q    <= tick_d;
    end
  end

  assign pend_in_range = ({1'b0, pend_q.ch} < 4'(NUM_CH));
  assign applied       = |(load & wrap);

  // Pending slot: capture on handshake, retire when the target channel
  // takes it or immediately when the index names no channel.
  always_comb begin
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    if (pend_valid_q) begin
      if (!pend_in_range || applied) begin
        pend_valid_d = 1'b0;
      end
    end else if (cfg_valid) begin
      pend_valid_d = 1'b1;
      pend_d.ch    = ch_idx_t'(cfg_ch);
      pend_d.div   = CFG_DIV_W'(cfg_div);
`ifdef CLK_DIV_DUTY_EN
      pend_d.duty  = CFG_DIV_W'(cfg_duty);
`endif
    end
  end

  // Pending slot register; a reset drops any write in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
    end
  end

  // Only the low DIV_W bits of the widened config fields reach the channels.
  logic unused_pend_bits;
`ifdef CLK_DIV_DUTY_EN
  assign unused_pend_bits = ^{pend_q.div, pend_q.duty};
`else
  assign unused_pend_bits = ^pend_q.div;
`endif

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign load[gi] = pend_valid_q && (pend_q.ch == CH_IDX_W'(gi));

      clk_div_chan #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
      ) u_chan (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick_q),
        .load      (load[gi]),
        .load_div  (pend_q.div[DIV_W-1:0]),
`ifdef CLK_DIV_DUTY_EN
        .load_duty (pend_q.duty[DIV_W-1:0]),
`endif
        .wrap      (wrap[gi]),
        .ch_out    (ch_out[gi]),
        .ch_stb    (ch_stb[gi])
      );
    end
  endgenerate

  assign cfg_ready = !pend_valid_q;
  assign tick      = tick_q;

endmodule
